accel_sequencer: RTL and testbench

- Bus-master controller that drives the memory-mapped N-operand product accelerator over its native valid/ready memory interface.
- Accepts one command holding N 32-bit operands.
- Writes each operand to the accelerator's write window, reads back the 64-bit product as two 32-bit words, then returns the product on a result handshake.
- Sits between a DMA/coprocessor front end and the accelerator, so the CPU no longer has to issue the N+2 bus accesses itself.

---
 rtl/accel_sequencer_if.sv | 32 +++
 rtl/accel_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_accel_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_sequencer_if.sv
// Command, result and accelerator-bus signals of the product-accelerator sequencer.
interface accel_sequencer_if #(
  parameter int unsigned N = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [32*N-1:0]   cmd_operands;
  logic              res_valid;
  logic              res_ready;
  logic [63:0]       res_data;
  logic              res_error;
  logic              mem_valid;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;

  // Sequencer side: consumes commands, produces results, masters the memory bus.
  modport master (
    input  cmd_valid, cmd_operands, res_ready, mem_ready, mem_rdata,
    output cmd_ready, res_valid, res_data, res_error,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  // Environment side: command source, result sink and accelerator slave.
  modport slave (
    output cmd_valid, cmd_operands, res_ready, mem_ready, mem_rdata,
    input  cmd_ready, res_valid, res_data, res_error,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/accel_sequencer.sv
// Bus-master sequencer: writes N operands to the product accelerator, reads the
// 64-bit product back as two words and returns it on a result handshake.
module accel_sequencer #(
  parameter logic [31:0] ADDR_WRITE = 32'h0110_0000,
  parameter logic [31:0] ADDR_READ  = 32'h0130_0000,
  parameter int unsigned N          = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  accel_sequencer_if.master  bus
);

  localparam int unsigned   SW         = $clog2(N + 2);
  localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
  localparam int unsigned   OW         = 32 * N;
  localparam logic [SW-1:0] STEP_RD_LO = SW'(N);
  localparam logic [SW-1:0] STEP_RD_HI = SW'(N + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [OW-1:0]   ops_q, ops_d;
  logic [63:0]     hold_q, hold_d;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic            res_valid_q, res_valid_d;
  logic [63:0]     res_data_q, res_data_d;
  logic            res_error_q, res_error_d;
  logic            cmd_ready_c;
  logic            load_req;
  logic            abort;

  // A stale acknowledge left over from an aborted transfer must drain before a new command.
  assign cmd_ready_c   = (state_q == ST_IDLE) && !bus.mem_ready;
  assign bus.cmd_ready = cmd_ready_c;

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_error = res_error_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      tmo_q       <= '0;
      ops_q       <= '0;
      hold_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tmo_q       <= tmo_d;
      ops_q       <= ops_d;
      hold_q      <= hold_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  // Next-state logic: step through N writes and two reads, with a per-phase timeout.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tmo_d       = tmo_q;
    ops_d       = ops_q;
    hold_d      = hold_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    load_req    = 1'b0;
    abort       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_c) begin
          ops_d    = bus.cmd_operands;
          step_d   = '0;
          load_req = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          if (step_q == STEP_RD_LO) begin
            hold_d[31:0] = bus.mem_rdata;
          end else if (step_q == STEP_RD_HI) begin
            hold_d[63:32] = bus.mem_rdata;
          end
          tmo_d   = '0;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (!bus.mem_ready) begin
          if (step_q != STEP_RD_HI) begin
            step_d   = step_q + SW'(1);
            load_req = 1'b1;
          end else begin
            state_d     = ST_DONE;
            res_data_d  = hold_q;
            res_error_d = 1'b0;
          end
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: begin
        res_valid_d = 1'b1;
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Launch the request for step_d; mem_valid rises on the same edge as the step change.
    if (load_req) begin
      state_d     = ST_REQ;
      tmo_d       = '0;
      mem_valid_d = 1'b1;
      if (step_d < STEP_RD_LO) begin
        mem_addr_d  = ADDR_WRITE + (32'(step_d) << 2);
        mem_wstrb_d = 4'b1111;
        mem_wdata_d = '0;
        for (int unsigned k = 0; k < N; k++) begin
          if (step_d == SW'(k)) begin
            mem_wdata_d = ops_d[32*k +: 32];
          end
        end
      end else begin
        mem_addr_d  = (step_d == STEP_RD_HI) ? ADDR_READ + 32'd4 : ADDR_READ;
        mem_wdata_d = '0;
        mem_wstrb_d = 4'b0000;
      end
    end

    // Timeout: drop the request, skip the remaining steps and report an error result.
    if (abort) begin
      mem_valid_d = 1'b0;
      res_data_d  = '0;
      res_error_d = 1'b1;
      tmo_d       = '0;
      state_d     = ST_DONE;
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Scoreboard bench for accel_sequencer with a behavioural product-accelerator slave.
module tb_accel_sequencer;

  localparam int unsigned N          = 3;
  localparam int unsigned TIMEOUT    = 16;
  localparam logic [31:0] ADDR_WRITE = 32'h0110_0000;
  localparam logic [31:0] ADDR_READ  = 32'h0130_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_txn_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } res_txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accel_sequencer_if #(.N(N)) bus ();

  accel_sequencer #(
    .ADDR_WRITE(ADDR_WRITE),
    .ADDR_READ (ADDR_READ),
    .N         (N),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_cyc = 0;

  bus_txn_t bus_q[$];
  res_txn_t res_q[$];
  int       lat_q[$];

  int          slv_delay = 0;
  bit          slv_never = 1'b0;
  bit          stick     = 1'b0;
  bit          rand_bp   = 1'b0;
  int          scnt      = 0;
  logic [31:0] acc_regs [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] product(input logic [32*N-1:0] v);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < N; k++) p = p * 64'(v[32*k +: 32]);
    return p;
  endfunction

  function automatic logic [32*N-1:0] pack3(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
    return {c, b, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accelerator slave: acknowledges after slv_delay cycles, holds ready until valid drops.
  always @(posedge clk) begin
    logic [32*N-1:0] regs_v;
    logic [63:0]     p;
    if (bus.mem_ready) begin
      if (!bus.mem_valid && !stick) begin
        bus.mem_ready <= 1'b0;
        bus.mem_rdata <= 32'hDEAD_BEEF;
      end
    end else if (bus.mem_valid && !slv_never) begin
      if (scnt >= slv_delay) begin
        scnt          <= 0;
        bus.mem_ready <= 1'b1;
        if (bus.mem_wstrb == 4'hF) begin
          for (int k = 0; k < N; k++)
            if (bus.mem_addr == ADDR_WRITE + 32'(4 * k)) acc_regs[k] <= bus.mem_wdata;
        end else begin
          for (int k = 0; k < N; k++) regs_v[32*k +: 32] = acc_regs[k];
          p = product(regs_v);
          if (bus.mem_addr == ADDR_READ)              bus.mem_rdata <= p[31:0];
          else if (bus.mem_addr == ADDR_READ + 32'd4) bus.mem_rdata <= p[63:32];
        end
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
    end
  end

  // Random result backpressure.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: compare each accepted access with the expected sequence; check request stability.
  logic        pv = 1'b0, phs = 1'b0;
  logic [31:0] pa, pw;
  logic [3:0]  ps;
  always @(negedge clk) begin
    bus_txn_t e;
    if (!reset) begin
      if (pv && !phs && bus.mem_valid) begin
        chk("mem_addr_stable",  bus.mem_addr,  pa);
        chk("mem_wdata_stable", bus.mem_wdata, pw);
        chk("mem_wstrb_stable", bus.mem_wstrb, ps);
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got access addr %0h, required none", bus.mem_addr);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr",  bus.mem_addr,  e.addr);
          chk("bus_wdata", bus.mem_wdata, e.wdata);
          chk("bus_wstrb", bus.mem_wstrb, e.wstrb);
        end
      end
    end
    pv  = bus.mem_valid && !reset;
    phs = bus.mem_valid && bus.mem_ready;
    pa  = bus.mem_addr;
    pw  = bus.mem_wdata;
    ps  = bus.mem_wstrb;
  end

  // Result monitor: latency, hold-under-backpressure, and scoreboard comparison.
  logic        prv = 1'b0, prhs = 1'b0, pe;
  logic [63:0] pd;
  always @(negedge clk) begin
    res_txn_t r;
    int       l;
    if (!reset) begin
      if (bus.res_valid && !prv && lat_q.size() > 0) begin
        l = lat_q.pop_front();
        if (l >= 0) chk("res_latency", 64'(cyc - hs_cyc), 64'(l));
      end
      if (prv && !prhs) begin
        chk("res_valid_held", bus.res_valid, 1'b1);
        chk("res_data_held",  bus.res_data,  pd);
        chk("res_error_held", bus.res_error, pe);
      end
      if (bus.res_valid) chk("cmd_ready_low_while_result", bus.cmd_ready, 1'b0);
      if (bus.res_valid && bus.res_ready) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: got result %0h, required none", bus.res_data);
        end else begin
          r = res_q.pop_front();
          chk("res_data",  bus.res_data,  r.data);
          chk("res_error", bus.res_error, r.err);
        end
      end
    end
    prv  = bus.res_valid && !reset;
    prhs = bus.res_valid && bus.res_ready;
    pd   = bus.res_data;
    pe   = bus.res_error;
  end

  // Offer a command and, on acceptance, push the expected bus accesses and result.
  task automatic send_cmd(input logic [32*N-1:0] v, input logic [63:0] exp_d,
                          input logic exp_e, input int exp_lat, input bit exp_bus);
    bit done = 1'b0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_operands = v;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        if (exp_bus) begin
          for (int k = 0; k < N; k++)
            bus_q.push_back('{ADDR_WRITE + 32'(4 * k), v[32*k +: 32], 4'hF});
          bus_q.push_back('{ADDR_READ, 32'd0, 4'h0});
          bus_q.push_back('{ADDR_READ + 32'd4, 32'd0, 4'h0});
        end
        res_q.push_back('{exp_d, exp_e});
        lat_q.push_back(exp_lat);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        done   = 1'b1;
      end
    end
    bus.cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got no handshake in 300 cycles, required acceptance");
    end
  endtask

  task automatic wait_done(input string nm);
    int i = 0;
    while ((res_q.size() != 0 || bus.res_valid) && i < 1000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (i >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got result pending after 1000 cycles, required completion", nm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [32*N-1:0] v;
    logic [31:0]     w;
    int              d, cnt, found;
    bit              ok;

    reset            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_operands = '0;
    bus.res_ready    = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_mem_valid", bus.mem_valid, 1'b0);
    chk("rst_mem_addr",  bus.mem_addr,  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 4'd0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data",  bus.res_data,  64'd0);
    chk("rst_res_error", bus.res_error, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;

    // Basic product and 64-bit truncation.
    send_cmd(pack3(32'd3, 32'd5, 32'd7), 64'd105, 1'b0, 21, 1'b1);
    wait_done("basic");
    send_cmd(pack3(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFC_0000_0002, 1'b0, 21, 1'b1);
    wait_done("overflow");

    // Backpressure: result held 10 cycles while a second command waits.
    bus.res_ready = 1'b0;
    send_cmd(pack3(32'd3, 32'd5, 32'd7), 64'd105, 1'b0, 21, 1'b1);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (bus.res_valid) found = 1;
    end
    chk("bp_res_valid_seen", 64'(found), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_operands = pack3(32'd2, 32'd2, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    send_cmd(pack3(32'd2, 32'd2, 32'd2), 64'd8, 1'b0, 21, 1'b1);
    wait_done("backpressure");

    // Timeout: slave never acknowledges.
    slv_never = 1'b1;
    send_cmd(pack3(32'd1, 32'd2, 32'd3), 64'd0, 1'b1, TIMEOUT + 1, 1'b0);
    cnt = 0;
    ok  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.mem_valid) break;
      cnt++;
      if (bus.mem_addr != ADDR_WRITE || bus.mem_wstrb != 4'hF) ok = 1'b0;
    end
    chk("timeout_valid_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("timeout_req_fields", 64'(ok), 64'd1);
    wait_done("timeout");
    slv_never = 1'b0;

    // Reset during the step-1 write while mem_ready is high.
    send_cmd(pack3(32'd1, 32'd2, 32'd3), 64'd6, 1'b0, 21, 1'b1);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mem_valid && bus.mem_ready && bus.mem_addr == ADDR_WRITE + 32'd4) found = 1;
    end
    chk("rstmid_step1_seen", 64'(found), 64'd1);
    #1;
    reset = 1'b1;
    stick = 1'b1;
    @(posedge clk);
    bus_q.delete();
    res_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("rstmid_mem_valid", bus.mem_valid, 1'b0);
    chk("rstmid_res_valid", bus.res_valid, 1'b0);
    chk("rstmid_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_cmd_ready_stale", bus.cmd_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    stick = 1'b0;
    send_cmd(pack3(32'd4, 32'd5, 32'd6), 64'd120, 1'b0, 21, 1'b1);
    wait_done("reset_mid");

    // Slow slave.
    slv_delay = 5;
    send_cmd(pack3(32'd3, 32'd5, 32'd7), 64'd105, 1'b0, (4 + 5) * (N + 2) + 1, 1'b1);
    wait_done("slow");

    // Random operands, slave delays and result backpressure against the product model.
    for (int it = 0; it < 20; it++) begin
      d         = $urandom_range(0, 3);
      slv_delay = d;
      rand_bp   = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 3))
          0:       w = 32'hFFFF_FFFF;
          1:       w = 32'($urandom_range(0, 15));
          default: w = $urandom;
        endcase
        v[32*k +: 32] = w;
      end
      send_cmd(v, product(v), 1'b0, (4 + d) * (N + 2) + 1, 1'b1);
      wait_done("random");
      rand_bp = 1'b0;
      @(posedge clk);
      #2;
      bus.res_ready = 1'b1;
    end

    repeat (5) @(posedge clk);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    chk("res_queue_drained", 64'(res_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
